// File: rtl/tx_client_arb_pkg.sv
// Shared types and helpers for the transmit-client round-robin arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    XFER     = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int N_CL_DEFAULT = 3;

  // Width of a client index / priority pointer; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W_DEFAULT = ptr_width(N_CL_DEFAULT);

endpackage

// File: rtl/tx_client_arb_if.sv
// Ethernet core transmit client port: req/length/ack/strobe/warn/data.
interface tx_client_arb_if #(
  parameter int jumbo_dw = 14
);
  logic                tx_req;
  logic [jumbo_dw-1:0] tx_len;
  logic                tx_ack;
  logic                tx_strobe;
  logic                tx_warn;
  logic [7:0]          tx_data;

  modport master (output tx_req, tx_len, tx_data, input tx_ack, tx_strobe, tx_warn);
  modport slave  (input tx_req, tx_len, tx_data, output tx_ack, tx_strobe, tx_warn);
endinterface

// File: rtl/tx_client_arb_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping.
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter  int n_cl = 3,
  localparam int PW   = ptr_width(n_cl)
) (
  input  logic [n_cl-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [n_cl-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic [PW-1:0] cand;

  // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int k = n_cl - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % n_cl);
      if (req[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = cand;
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_client_arb.sv
// Round-robin sharing of one Ethernet transmit client port among n_cl clients;
// a grant is held for a whole packet and handshakes/data are routed to the winner.
module tx_client_arb
  import tx_arb_pkg::*;
#(
  parameter int jumbo_dw    = 14,
  parameter int n_cl        = 3,
  parameter int ack_timeout = 4095
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [n_cl-1:0]          cl_req,
  input  logic [n_cl*jumbo_dw-1:0] cl_len,
  input  logic [n_cl*8-1:0]        cl_data,
  output logic [n_cl-1:0]          cl_ack,
  output logic [n_cl-1:0]          cl_strobe,
  output logic [n_cl-1:0]          cl_warn,
  tx_client_arb_if.master          tx,
  output logic [n_cl-1:0]          grant,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [15:0]              pkt_count
);

  localparam int PW      = ptr_width(n_cl);
  localparam int CW      = (ack_timeout > 1) ? $clog2(ack_timeout) : 1;
  localparam int TO_LAST = (ack_timeout > 0) ? ack_timeout - 1 : 0;

  state_t              state, state_d;
  logic [n_cl-1:0]     grant_d;
  logic [PW-1:0]       gidx, gidx_d, ptr, ptr_d, next_ptr;
  logic                tx_req_q, tx_req_d;
  logic [jumbo_dw-1:0] tx_len_q, tx_len_d;
  logic                timeout_d;
  logic [15:0]         pkt_count_d;
  logic [CW-1:0]       wcnt, wcnt_d;
  logic                strobe_q, strobe_d;

  logic [n_cl-1:0]     pick_oh;
  logic [PW-1:0]       pick_idx;
  logic                pick_any;

  rr_pick #(.n_cl(n_cl)) u_pick (
    .req    (cl_req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_ptr = (gidx == PW'(n_cl - 1)) ? '0 : gidx + PW'(1);

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    gidx_d      = gidx;
    ptr_d       = ptr;
    tx_req_d    = tx_req_q;
    tx_len_d    = tx_len_q;
    timeout_d   = 1'b0;
    pkt_count_d = pkt_count;
    wcnt_d      = wcnt;
    // Strobe history only counts inside a transfer, so a stale high cannot end the next packet early.
    strobe_d    = (state == XFER) && tx.tx_strobe;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          grant_d  = pick_oh;
          gidx_d   = pick_idx;
          tx_req_d = 1'b1;
          tx_len_d = cl_len[int'(pick_idx)*jumbo_dw +: jumbo_dw];
          wcnt_d   = '0;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        wcnt_d = wcnt + CW'(1);
        if (tx.tx_ack) begin
          tx_req_d = 1'b0;
          state_d  = XFER;
        end else if (!cl_req[gidx]) begin
          tx_req_d = 1'b0;
          grant_d  = '0;
          state_d  = IDLE;
        end else if (ack_timeout != 0 && wcnt == CW'(TO_LAST)) begin
          timeout_d = 1'b1;
          tx_req_d  = 1'b0;
          grant_d   = '0;
          ptr_d     = next_ptr;
          state_d   = IDLE;
        end
      end
      XFER: begin
        if (strobe_q && !tx.tx_strobe) state_d = GAP;
      end
      GAP: begin
        pkt_count_d = pkt_count + 16'd1;
        ptr_d       = next_ptr;
        grant_d     = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      ptr         <= '0;
      tx_req_q    <= 1'b0;
      tx_len_q    <= '0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
      wcnt        <= '0;
      strobe_q    <= 1'b0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      gidx        <= gidx_d;
      ptr         <= ptr_d;
      tx_req_q    <= tx_req_d;
      tx_len_q    <= tx_len_d;
      timeout_err <= timeout_d;
      pkt_count   <= pkt_count_d;
      wcnt        <= wcnt_d;
      strobe_q    <= strobe_d;
    end
  end

  // Handshakes pass through combinationally; the state gate drops strobes seen in IDLE/GAP.
  assign cl_ack    = (state == WAIT_ACK && tx.tx_ack)    ? grant : '0;
  assign cl_strobe = (state == XFER     && tx.tx_strobe) ? grant : '0;
  assign cl_warn   = (state == XFER     && tx.tx_warn)   ? grant : '0;
  assign busy      = (state != IDLE);
  assign tx.tx_req = tx_req_q;
  assign tx.tx_len = tx_len_q;

  always_comb begin
    tx.tx_data = 8'h00;
    if (|grant) tx.tx_data = cl_data[int'(gidx)*8 +: 8];
  end

endmodule

// File: tb/tb_tx_client_arb.sv
// Randomised bench for tx_client_arb against a priority-list reference model.
module tb_tx_client_arb;

  localparam int N  = 3;
  localparam int DW = 14;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    cl_req;
  logic [N*DW-1:0] cl_len;
  logic [N*8-1:0]  cl_data;
  logic [N-1:0]    cl_ack, cl_strobe, cl_warn, grant;
  logic            busy, timeout_err;
  logic [15:0]     pkt_count;

  tx_client_arb_if #(.jumbo_dw(DW)) tx_if ();

  tx_client_arb #(.jumbo_dw(DW), .n_cl(N), .ack_timeout(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cl_req      (cl_req),
    .cl_len      (cl_len),
    .cl_data     (cl_data),
    .cl_ack      (cl_ack),
    .cl_strobe   (cl_strobe),
    .cl_warn     (cl_warn),
    .tx          (tx_if),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .pkt_count   (pkt_count)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;   // model: index of highest-priority client
  int pkt_m  = 0;   // model: completed packets

  // Reference winner: scan the priority list ptr, ptr+1, ... modulo N.
  function automatic int model_pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] len_of(input int g);
    return cl_len[g*DW +: DW];
  endfunction

  task automatic randomize_lens();
    for (int i = 0; i < N; i++) cl_len[i*DW +: DW] = DW'($urandom_range(1, 9000));
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) cl_data[i*8 +: 8] = 8'($urandom);
  endtask

  task automatic wait_tx_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (tx_if.tx_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Plays the core side of one packet and records what the DUT showed; callers judge it.
  task automatic run_pkt(input int exp_g, input int len, input bit drop_at_ack,
                         output logic [N-1:0] g_obs, output logic [DW-1:0] len_obs,
                         output logic [N-1:0] ack_obs, output logic [N-1:0] xfer_grant,
                         output int bad, output bit ok);
    logic w;
    bad = 0; g_obs = '0; len_obs = '0; ack_obs = '0; xfer_grant = '0;
    wait_tx_req(ok);
    if (!ok) return;
    g_obs   = grant;
    len_obs = tx_if.tx_len;
    @(negedge clk);
    tx_if.tx_ack = 1'b1;
    if (drop_at_ack) cl_req = '0;
    #1 ack_obs = cl_ack;
    @(posedge clk); #1;
    xfer_grant = grant;
    if (tx_if.tx_req !== 1'b0) bad++;
    @(negedge clk);
    tx_if.tx_ack = 1'b0;
    for (int i = 0; i < len; i++) begin
      randomize_data();
      w = 1'($urandom_range(0, 1));
      tx_if.tx_strobe = 1'b1;
      tx_if.tx_warn   = w;
      #1;
      if (tx_if.tx_data !== cl_data[exp_g*8 +: 8] || cl_strobe !== oh(exp_g) ||
          cl_warn !== (w ? oh(exp_g) : '0)) bad++;
      @(negedge clk);
    end
    tx_if.tx_strobe = 1'b0;
    tx_if.tx_warn   = 1'b0;
    #1 if (cl_strobe !== '0) bad++;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected %b", grant, 3'b000); end
    checks++; if (tx_if.tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b expected 0", tx_if.tx_req); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx_if.tx_len !== '0) begin errors++; $display("FAIL reset_tx_len: got %0d expected 0", tx_if.tx_len); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    checks++; if ((cl_ack | cl_strobe | cl_warn) !== '0) begin errors++; $display("FAIL reset_client_outs: got %b expected 000", cl_ack | cl_strobe | cl_warn); end
    checks++; if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_if.tx_data); end
    ptr_m = 0; pkt_m = 0;
  endtask

  task automatic test_single_client();
    logic [N-1:0] g, a, xg; logic [DW-1:0] l; int bad; bit ok;
    @(negedge clk);
    cl_len[1*DW +: DW] = DW'(64);
    cl_req = 3'b010;
    #1;
    checks++; if (tx_if.tx_req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b expected 0", tx_if.tx_req); end
    @(posedge clk); #1;
    checks++; if (tx_if.tx_req !== 1'b1) begin errors++; $display("FAIL single_req_latency: got %b expected 1", tx_if.tx_req); end
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", grant); end
    checks++; if (tx_if.tx_len !== DW'(64)) begin errors++; $display("FAIL single_tx_len: got %0d expected 64", tx_if.tx_len); end
    run_pkt(1, 64, 1'b0, g, l, a, xg, bad, ok);
    cl_req = '0;
    pkt_m++; ptr_m = 2;
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout_wait: got no tx_req expected tx_req"); end
    checks++; if (a !== 3'b010) begin errors++; $display("FAIL single_cl_ack: got %b expected 010", a); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_xfer: got %0d bad cycles expected 0", bad); end
    checks++; if (pkt_count !== 16'(pkt_m)) begin errors++; $display("FAIL single_pkt_count: got %0d expected %0d", pkt_count, pkt_m); end
    checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got grant %b busy %b expected 000 0", grant, busy); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g, a, xg, req; logic [DW-1:0] l; int bad, e, prev; bit ok;
    prev = -1;
    randomize_lens();
    for (int p = 0; p < 22; p++) begin
      if (p < 6) req = '1;
      else begin
        req = N'($urandom_range(1, (1 << N) - 1));
        randomize_lens();
      end
      cl_req = req;
      e = model_pick(req, ptr_m);
      run_pkt(e, $urandom_range(1, 20), 1'b0, g, l, a, xg, bad, ok);
      pkt_m++; ptr_m = (e + 1) % N;
      checks++; if (g !== oh(e)) begin errors++; $display("FAIL rr_grant pkt %0d: got %b expected %b", p, g, oh(e)); end
      checks++; if (l !== len_of(e)) begin errors++; $display("FAIL rr_tx_len pkt %0d: got %0d expected %0d", p, l, len_of(e)); end
      checks++; if (a !== oh(e) || bad !== 0) begin errors++; $display("FAIL rr_xfer pkt %0d: got ack %b bad %0d expected ack %b bad 0", p, a, bad, oh(e)); end
      checks++; if (pkt_count !== 16'(pkt_m)) begin errors++; $display("FAIL rr_pkt_count pkt %0d: got %0d expected %0d", p, pkt_count, pkt_m); end
      if (prev >= 0 && (req & ~oh(prev)) != '0) begin
        checks++; if (g === oh(prev)) begin errors++; $display("FAIL rr_fairness pkt %0d: got %b again expected another client", p, g); end
      end
      prev = e;
    end
    cl_req = '0;
  endtask

  task automatic test_withdrawal();
    logic [N-1:0] g, a, xg; logic [DW-1:0] l; int bad, e; bit ok;
    cl_req = 3'b010;
    run_pkt(1, 4, 1'b0, g, l, a, xg, bad, ok);
    cl_req = '0;
    pkt_m++; ptr_m = 2;
    cl_req = 3'b100;
    wait_tx_req(ok);
    checks++; if (!ok || grant !== 3'b100) begin errors++; $display("FAIL wd_grant: got %b expected 100", grant); end
    @(negedge clk);
    cl_req = '0;
    @(posedge clk); #1;
    checks++; if (tx_if.tx_req !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL wd_release: got req %b grant %b busy %b expected 0 000 0", tx_if.tx_req, grant, busy); end
    checks++; if (pkt_count !== 16'(pkt_m)) begin errors++; $display("FAIL wd_pkt_count: got %0d expected %0d", pkt_count, pkt_m); end
    cl_req = '1;
    e = model_pick(3'b111, ptr_m);
    run_pkt(e, 3, 1'b0, g, l, a, xg, bad, ok);
    cl_req = '0;
    pkt_m++; ptr_m = (e + 1) % N;
    checks++; if (g !== oh(e) || bad !== 0) begin errors++; $display("FAIL wd_ptr_kept: got %b bad %0d expected %b bad 0", g, bad, oh(e)); end
  endtask

  task automatic test_timeout();
    logic [N-1:0] g, a, xg; logic [DW-1:0] l; int bad, e, cnt; bit ok, seen;
    cl_req = 3'b011;
    e = model_pick(3'b011, ptr_m);
    wait_tx_req(ok);
    checks++; if (!ok || grant !== oh(e)) begin errors++; $display("FAIL to_grant: got %b expected %b", grant, oh(e)); end
    cnt = 1; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (timeout_err === 1'b1) begin seen = 1'b1; break; end
      cnt++;
    end
    checks++; if (!seen || cnt !== TO) begin errors++; $display("FAIL to_cycles: got %0d (seen %b) expected %0d", cnt, seen, TO); end
    checks++; if (tx_if.tx_req !== 1'b0 || grant !== '0) begin errors++; $display("FAIL to_release: got req %b grant %b expected 0 000", tx_if.tx_req, grant); end
    ptr_m = (e + 1) % N;
    e = model_pick(3'b011, ptr_m);
    @(posedge clk); #1;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", timeout_err); end
    checks++; if (grant !== oh(e)) begin errors++; $display("FAIL to_next_grant: got %b expected %b", grant, oh(e)); end
    run_pkt(e, 5, 1'b1, g, l, a, xg, bad, ok);
    pkt_m++; ptr_m = (e + 1) % N;
    checks++; if (a !== oh(e) || bad !== 0 || pkt_count !== 16'(pkt_m)) begin
      errors++; $display("FAIL to_followup: got ack %b bad %0d count %0d expected %b 0 %0d", a, bad, pkt_count, oh(e), pkt_m); end
  endtask

  task automatic test_reset_mid_xfer();
    logic [N-1:0] g, a, xg; logic [DW-1:0] l; int bad, e; bit ok;
    randomize_lens();
    cl_req = '1;
    wait_tx_req(ok);
    @(negedge clk); tx_if.tx_ack = 1'b1;
    @(negedge clk); tx_if.tx_ack = 1'b0;
    tx_if.tx_strobe = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant !== '0 || busy !== 1'b0 || tx_if.tx_req !== 1'b0) begin
      errors++; $display("FAIL rst_async_state: got grant %b busy %b req %b expected 000 0 0", grant, busy, tx_if.tx_req); end
    checks++; if (cl_strobe !== '0 || tx_if.tx_data !== 8'h00) begin
      errors++; $display("FAIL rst_async_outs: got strobe %b data %h expected 000 00", cl_strobe, tx_if.tx_data); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d expected 0", pkt_count); end
    tx_if.tx_strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0; pkt_m = 0;
    e = model_pick(3'b111, ptr_m);
    run_pkt(e, 6, 1'b1, g, l, a, xg, bad, ok);
    pkt_m++; ptr_m = (e + 1) % N;
    checks++; if (g !== oh(e) || bad !== 0) begin errors++; $display("FAIL rst_ptr_zero: got %b bad %0d expected %b bad 0", g, bad, oh(e)); end
    checks++; if (pkt_count !== 16'(pkt_m)) begin errors++; $display("FAIL rst_recount: got %0d expected %0d", pkt_count, pkt_m); end
  endtask

  task automatic test_ack_and_withdraw();
    logic [N-1:0] g, a, xg; logic [DW-1:0] l; int bad, e; bit ok;
    cl_req = 3'b010;
    e = model_pick(3'b010, ptr_m);
    run_pkt(e, 8, 1'b1, g, l, a, xg, bad, ok);
    pkt_m++; ptr_m = (e + 1) % N;
    checks++; if (a !== oh(e)) begin errors++; $display("FAIL aw_ack: got %b expected %b", a, oh(e)); end
    checks++; if (xg !== oh(e)) begin errors++; $display("FAIL aw_grant_kept: got %b expected %b", xg, oh(e)); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL aw_xfer: got %0d bad cycles expected 0", bad); end
    checks++; if (pkt_count !== 16'(pkt_m)) begin errors++; $display("FAIL aw_pkt_count: got %0d expected %0d", pkt_count, pkt_m); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cl_req = '0; cl_len = '0; cl_data = '0;
    tx_if.tx_ack = 1'b0; tx_if.tx_strobe = 1'b0; tx_if.tx_warn = 1'b0;
    test_reset();
    test_single_client();
    test_round_robin();
    test_withdrawal();
    test_timeout();
    test_reset_mid_xfer();
    test_ack_and_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_client_arb.md
Name: tx_client_arb

Overview:
- Shares one Ethernet transmit client port among N_CL requesting clients, using round-robin priority.
- The transmit port uses the req/length/ack/strobe/warn/data contract.
- The block sits between the Ethernet core's transmit client slot and several tx-capable clients (client_tx, client_thru, mem_gateway-style).
- It holds one grant for a whole packet and forwards handshake and data between the granted client and the port.

Parameters:
- jumbo_dw, 14, width of a length field (octets).
- n_cl, 3, number of clients, allowed range 2..8.
- ack_timeout, 4095, maximum cycles to wait for tx_ack after tx_req rises; 0 disables the timeout.

Ports:
- clk  in  1  system clock (125 MHz Ethernet domain).
- rst_n  in  1  asynchronous active-low reset.
- cl_req  in  n_cl  per-client packet request, level; held until that client's ack.
- cl_len  in  n_cl*jumbo_dw  packed per-client lengths; client i occupies bits [i*jumbo_dw +: jumbo_dw]; stable while its req is high.
- cl_data  in  n_cl*8  packed per-client tx octets.
- cl_ack  out  n_cl  one-cycle ack, routed to the granted client only.
- cl_strobe  out  n_cl  data strobe, routed to the granted client only.
- cl_warn  out  n_cl  pre-strobe warning, routed to the granted client only.
- tx_req  out  1  request to the core port.
- tx_len  out  jumbo_dw  length of the granted client.
- tx_ack  in  1  one-cycle ack from the core port.
- tx_strobe  in  1  core data strobe.
- tx_warn  in  1  core warning.
- tx_data  out  8  octet from the granted client.
- grant  out  n_cl  one-hot grant, all-zero when idle.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when an ack wait times out.
- pkt_count  out  16  count of completed packets, wraps at 16'hffff.

Behaviour:
- Reset (asynchronous, rst_n=0) sets:
  - state=IDLE; grant=0; tx_req=0; tx_len=0; cl_ack/cl_strobe/cl_warn=0; timeout_err=0; pkt_count=0.
  - Priority pointer ptr=0, the index of the highest-priority client.
  - Reset asserted mid-packet aborts immediately; the core sees tx_req drop with no further forwarding.
- IDLE:
  - If any cl_req bit is high, select the first set bit searching ptr, ptr+1, … modulo n_cl.
  - Next cycle: grant is set one-hot, tx_len is registered from that client's cl_len, tx_req=1, and state moves to WAIT_ACK.
  - Request-to-tx_req latency is exactly 1 cycle.
- WAIT_ACK:
  - On tx_ack=1: cl_ack[g] is a combinational copy of tx_ack gated by grant, so it appears in the same cycle. Next cycle tx_req=0 and state moves to XFER.
  - If cl_req[g] drops without an ack (withdrawal): next cycle tx_req=0, grant=0, state moves to IDLE. ptr is unchanged and pkt_count is not incremented.
  - If a wait counter reaches ack_timeout (ack_timeout≠0): pulse timeout_err, set tx_req=0, grant=0, ptr=g+1 mod n_cl, and go to IDLE.
  - tx_ack and withdrawal in the same cycle: tx_ack wins.
- XFER:
  - cl_strobe[g]=tx_strobe and cl_warn[g]=tx_warn, both combinational and gated by grant.
  - tx_data=cl_data[g] as a combinational mux through the registered grant, adding zero cycles, so the client's existing data timing is preserved.
  - Packet end is the first falling edge of tx_strobe after it has been high (registered strobe history). On packet end, next state is GAP.
  - The arbiter does not count octets; length consistency is the core's responsibility.
- GAP:
  - One cycle. pkt_count+1 (wrapping), ptr=g+1 mod n_cl, grant=0, then IDLE.
  - The minimum spacing between one client's packet end and the next tx_req is therefore 2 cycles.
- Fairness: a continuously requesting client never wins twice in a row while any other client is requesting.
- Outputs for non-granted clients are always 0.
- When grant=0, tx_data=8'h00.
- Strobes arriving in IDLE or GAP are ignored and are not forwarded.

Decomposition:
- Shared package tx_arb_pkg holds:
  - state encoding constants IDLE=0, WAIT_ACK=1, XFER=2, GAP=3;
  - the width of the ptr index, clog2(n_cl).
- One sub-module is natural: rr_pick, a combinational round-robin first-set finder (req vector, ptr → one-hot plus index plus any).

Test Plan:
- Single client: cl_req=3'b010, cl_len[1]=64 → tx_req rises 1 cycle later, tx_len=64, grant=3'b010. tx_ack pulse → cl_ack[1] in the same cycle. 64-cycle strobe with tx_data tracking cl_data[1] at zero latency. Then pkt_count=1, ptr=2.
- All three clients request continuously: grant order 0,1,2,0,1,2; no client wins twice in a row; pkt_count=6 after six packets.
- Withdrawal: client 2 drops req while in WAIT_ACK → tx_req low the next cycle, grant=0, ptr unchanged, pkt_count unchanged.
- Timeout: ack_timeout=16, tx_ack never asserted → timeout_err pulses once after 16 wait cycles; tx_req low; next grant goes to the next requesting client.
- Reset mid-XFER: rst_n low during strobe → all outputs 0 immediately (asynchronously); after release the block returns to IDLE with ptr=0.
- Simultaneous tx_ack and cl_req drop → ack honoured, transfer proceeds normally.
